memory_control: RTL
===================

# memory_control

Sequential responder for the CPU's memory request strobes (iREN, dREN, dWEN) produced by the decode/control logic. It arbitrates instruction-fetch and data requests onto the single-ported RAM, holds each request until the RAM reports ACCESS, and returns registered load data with a one-cycle hit pulse. It sits between the datapath/request side and the RAM model, and flags a sticky error on RAM ERROR or timeout.

## Interface

Parameters:
- TIMEOUT, 255: maximum cycles an access may wait for ACCESS before it is aborted.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction fetch request.
- iaddr  in  32  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data to write.
- halt  in  1  CPU halted; blocks new fetches.
- ihit  out  1  one-cycle pulse; iload valid.
- iload  out  32  registered instruction word.
- dhit  out  1  one-cycle pulse; data access complete, dload valid for reads.
- dload  out  32  registered read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ramstate is ACCESS.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- mem_err  out  1  sticky error flag.

## Operation

- FSM states: IDLE, DACC, IACC.
- IDLE: if dREN or dWEN, latch daddr, dstore, and op (write if dWEN), then go to DACC. Else if iREN and not halt, latch iaddr, then go to IACC. Data requests have priority over fetches.
- dREN and dWEN both high: treated as a write.
- DACC/IACC: drive ramaddr/ramstore from the latched values; ramREN or ramWEN follows the latched op, with IACC always a read.
  - ramstate ACCESS: register ramload into dload/iload (reads only; dload holds its value on writes), pulse the matching hit, return to IDLE.
  - ramstate ERROR: set mem_err, return to IDLE, no hit.
  - wait counter reaches TIMEOUT: set mem_err, return to IDLE, no hit.
- Request dropped mid-access: the access still completes and the hit still pulses. Requesters ignore it.
- Latched address/data stay fixed for the whole access, regardless of input changes.
- IDLE drives ramREN=ramWEN=0 and ramaddr=0.
- mem_err is cleared only by nRST.

## Timing

- Reset values: state IDLE; ihit, dhit, ramREN, ramWEN, mem_err are 0; iload, dload, ramaddr, ramstore are 0; wait counter 0.
- Cycle 0: a request is sampled in IDLE.
- Cycle 1: RAM strobes are high, decoded combinationally from state.
- Hit timing: the hit and load data appear in the cycle after the first ACCESS cycle, for a minimum latency of 2 cycles. Each BUSY cycle adds one.
- Hit is high for exactly one cycle. The FSM is in IDLE during the hit cycle, so the next request is sampled in that same cycle.
- Maximum back-to-back throughput is one access per 2 cycles (IDLE + ACC).
- Wait counter: 8 bits wide, clamped at TIMEOUT, cleared on entry to DACC/IACC. The abort happens when the counter equals TIMEOUT while ramstate is not ACCESS.
- halt rising during an IACC: that fetch completes; no new fetch is accepted afterwards. Data requests are still served.
- nRST low mid-access: immediate return to reset values and strobes drop asynchronously. A partially performed RAM write is acceptable.

## Structure

- cpu_types_pkg owns:
  - word_t (32-bit);
  - ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3);
  - new mc_state_t (IDLE, DACC, IACC).
- Sub-module mem_timeout: a saturating wait counter with clear/enable inputs and an expired output, parameterised by TIMEOUT.

## Test plan

- Instruction fetch: iREN=1, iaddr=0x0000_0040, RAM returns ACCESS immediately with ramload=0x2401_0005 → ramREN=1 in cycle 1, ihit=1 and iload=0x2401_0005 in cycle 2, ramWEN never high.
- Write with waits: dWEN=1, daddr=0x0000_0100, dstore=0xDEAD_BEEF, RAM BUSY for 3 cycles then ACCESS → ramWEN held 4 cycles with ramaddr/ramstore stable, dhit in cycle 5, dload unchanged.
- Simultaneous iREN and dREN: data read at 0x0000_0200 is served first and dhit pulses. The fetch is then accepted in the dhit cycle and ihit follows 2 cycles later.
- Halt: with halt=1 and iREN=1 held for 10 cycles → ramREN stays 0 and ihit never pulses. A subsequent dREN is still served with dhit.
- Errors:
  - ramstate=ERROR during DACC → mem_err=1 next cycle, no dhit, state IDLE.
  - Separately, TIMEOUT=4 with RAM stuck BUSY → mem_err=1 after 4 wait cycles.
- Reset mid-access: nRST asserted low during DACC → ramREN/ramWEN drop immediately and all outputs hold their reset values. After release, a new fetch completes in 2 cycles.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, RAM handshake states and the memory controller FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } mc_state_t;

    localparam int WAIT_W = 8;

endpackage

// File: rtl/mem_timeout.sv
// Saturating wait counter: counts enabled cycles up to TIMEOUT and flags expiry while parked there.
module mem_timeout
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/memory_control.sv
// Arbitrates instruction fetches and data accesses onto a single-ported RAM, holding each
// request until ACCESS and returning registered load data with a one-cycle hit pulse.
module memory_control
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  logic      halt,
    output logic      ihit,
    output word_t     iload,
    output logic      dhit,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      mem_err
);

    mc_state_t state_q, state_d;
    word_t     addr_q, addr_d;
    word_t     store_q, store_d;
    word_t     iload_q, iload_d;
    word_t     dload_q, dload_d;
    logic      wr_q, wr_d;
    logic      ihit_q, ihit_d;
    logic      dhit_q, dhit_d;
    logic      err_q, err_d;

    logic      in_access;
    logic      done;
    logic      abort;
    logic      expired;

    assign in_access = (state_q != IDLE);
    assign done      = in_access && (ramstate == ACCESS);
    // A late ACCESS still wins over an expired counter.
    assign abort     = in_access && ((ramstate == ERROR) || (expired && (ramstate != ACCESS)));

    mem_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i    (CLK),
        .rst_ni   (nRST),
        .clr_i    (!in_access),
        .en_i     (in_access),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        store_d = store_q;
        wr_d    = wr_q;
        iload_d = iload_q;
        dload_d = dload_q;
        err_d   = err_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (dREN || dWEN) begin
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                    state_d = DACC;
                end else if (iREN && !halt) begin
                    addr_d  = iaddr;
                    wr_d    = 1'b0;
                    state_d = IACC;
                end
            end
            DACC: begin
                if (done) begin
                    dhit_d  = 1'b1;
                    if (!wr_q) begin
                        dload_d = ramload;
                    end
                    state_d = IDLE;
                end else if (abort) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            IACC: begin
                if (done) begin
                    ihit_d  = 1'b1;
                    iload_d = ramload;
                    state_d = IDLE;
                end else if (abort) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wr_q    <= wr_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign ramREN   = (state_q == IACC) || ((state_q == DACC) && !wr_q);
    assign ramWEN   = (state_q == DACC) && wr_q;
    assign ramaddr  = in_access ? addr_q : '0;
    assign ramstore = store_q;

    assign ihit    = ihit_q;
    assign dhit    = dhit_q;
    assign iload   = iload_q;
    assign dload   = dload_q;
    assign mem_err = err_q;

endmodule
